hub75_rx: RTL
=============

// Module: hub75_rx
// PURPOSE
//  HUB75 panel-side receiver: the sink end of the dspl_ctrl link. Samples sclk/latch/blank/RGB/row_sel
//  in the system clock domain and rebuilds 4-plane BCM data into 12-bit pixels per row.
//  Writes each completed row into a frame memory using the same layout the controller reads.
//  Used as a loopback checker and in the panel emulator.
// PARAMETERS
//  SREG_WIDTH  64  columns shifted per latch (per half)
//  ROWS        16  row_sel range; w_addr width = $clog2(ROWS*SREG_WIDTH)
// PORTS
//  clk         in   1   system clock (same clock as dspl_ctrl)
//  rst_n       in   1   synchronous reset, active-low
//  sclk        in   1   panel shift clock
//  latch       in   1   panel latch
//  blank       in   1   panel blank (1 = off)
//  din_top     in   3   RGB bits, top half ([0]->pixel[8+p], [1]->[4+p], [2]->[0+p])
//  din_btm     in   3   RGB bits, bottom half, same mapping
//  row_sel     in   4   row address
//  w_en        out  1   frame-memory write strobe
//  w_addr      out  10  row*SREG_WIDTH + col
//  w_data_top  out  12  rebuilt top pixel
//  w_data_btm  out  12  rebuilt bottom pixel
//  plane       out  2   plane assigned to the next latch
//  row_done    out  1   1-cycle pulse with the last write of a row
//  shift_err   out  1   sticky: latch seen after != SREG_WIDTH sclk rises
//  overrun     out  1   sticky: row completion while writeout busy
//  ontime      out  16  unblanked cycles of the previous plane (see CONFIGURATION)
//  ontime_vld  out  1   1-cycle pulse qualifying ontime
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all outputs 0, plane=0, shift count 0, edge regs 0, FSM IDLE.
//    Reset mid-writeout aborts it; w_en is 0 from the next cycle.
//  - sclk rise = sclk & !sclk_q. On that cycle din_* is shifted in. Shift count saturates at 2*SREG_WIDTH.
//    The n-th bit after the previous latch (0-based) is column n. Rises while latch=1 are ignored.
//  - latch rise = latch & !latch_q. Shift bits go to acc bit position plane; shift_err|=(count!=SREG_WIDTH);
//    count<=0; plane<=plane+1 (wraps 3->0).
//  - On a latch rise with plane==3: acc copies to out_buf, row_sel is captured as the row tag, FSM->WRITE.
//  - FSM IDLE/WRITE. WRITE starts at the cycle after the latch rise and lasts SREG_WIDTH consecutive cycles.
//    w_en=1 and col counts 0..SREG_WIDTH-1. row_done pulses with col==SREG_WIDTH-1, then IDLE.
//  - Latency: plane-3 latch rise at cycle N -> first write at N+1 -> last write at N+SREG_WIDTH.
//  - A plane-3 latch rise during WRITE sets overrun=1, reloads out_buf/row tag and restarts at col 0.
//  - Simultaneous sclk rise and latch rise in one cycle: the shift is dropped, the latch is processed.
//  - w_addr arithmetic is unsigned at w_addr width; row tag >= ROWS wraps modulo.
// CONFIGURATION
//  HUB75_RX_ONTIME_EN defined: 16-bit counter counts cycles with blank==0 and saturates at 16'hFFFF.
//    On each latch rise: ontime<=count, ontime_vld pulses 1 cycle, counter clears.
//    The value belongs to plane-1 (mod 4).
//  Not defined: ontime=0 and ontime_vld=0 permanently; no counter logic.
// STRUCTURE
//  Shared package hub75_pkg: NUM_PLANES=4, CH_BITS=4, pixel_t (logic[11:0]), rgb_t (logic[2:0]),
//    rx_state_t enum {RX_IDLE, RX_WRITE}.
//  Sub-module hub75_rx_half (shift reg + plane accumulator + out_buf for one half),
//    instantiated for top and bottom.
// TESTING
//  1. rst_n=0 for 3 cycles mid-traffic -> all outputs 0, plane=0, no w_en.
//  2. row_sel=5; 4 planes x 64 sclk pulses; pixel c={c[3:0],~c[3:0],c[3:0]}
//     -> 64 writes, w_addr 320..383, exact data, row_done at 383.
//  3. 63 sclk pulses then latch -> shift_err=1 and stays 1; accumulation continues.
//  4. Plane-3 latch while writeout is at col 10 -> overrun=1, next write at col 0 with new data.
//  5. rst_n=0 at writeout col 20 -> w_en=0 next cycle, plane=0, flags cleared.
//  6. HUB75_RX_ONTIME_EN: blank low 448 cycles, then latch -> ontime=448 with 1-cycle ontime_vld.
//     Without the macro -> both stay 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and helpers for the HUB75 receiver
package hub75_pkg;

  localparam int NUM_PLANES = 4;
  localparam int CH_BITS    = 4;

  typedef logic [11:0] pixel_t;
  typedef logic [2:0]  rgb_t;

  typedef enum logic {RX_IDLE, RX_WRITE} rx_state_t;

  // Drop one plane's RGB bits into a 12-bit pixel: [0]->R plane, [1]->G plane, [2]->B plane
  function automatic pixel_t set_plane(pixel_t px, rgb_t bits, logic [1:0] pl);
    pixel_t r;
    r = px;
    r[8 + pl] = bits[0];
    r[4 + pl] = bits[1];
    r[0 + pl] = bits[2];
    return r;
  endfunction

endpackage

// File: rtl/hub75_rx_half.sv
// rtl/hub75_rx_half.sv - shift register, plane accumulator and writeout buffer for one panel half
module hub75_rx_half
  import hub75_pkg::*;
#(
  parameter int SREG_WIDTH = 64,
  localparam int CW = $clog2(SREG_WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift_en,
  input  logic [CW-1:0] shift_col,
  input  rgb_t          din,
  input  logic          latch_en,
  input  logic [1:0]    plane,
  input  logic          load_en,
  input  logic [CW-1:0] rd_col,
  output pixel_t        rd_data
);

  rgb_t   sreg    [SREG_WIDTH];
  pixel_t acc     [SREG_WIDTH];
  pixel_t out_buf [SREG_WIDTH];

  // Shift columns in, merge them into the accumulator on latch, snapshot the full pixel on the last plane
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < SREG_WIDTH; c++) begin
        sreg[c]    <= '0;
        acc[c]     <= '0;
        out_buf[c] <= '0;
      end
    end else begin
      if (shift_en) sreg[shift_col] <= din;
      for (int c = 0; c < SREG_WIDTH; c++) begin
        if (latch_en) acc[c] <= set_plane(acc[c], sreg[c], plane);
        if (load_en)  out_buf[c] <= set_plane(acc[c], sreg[c], plane);
      end
    end
  end

  assign rd_data = out_buf[rd_col];

endmodule

// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 sink: rebuilds BCM planes into pixels and writes rows to frame memory (option: HUB75_RX_ONTIME_EN)
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int SREG_WIDTH = 64,
  parameter int ROWS       = 16,
  localparam int AW = $clog2(ROWS * SREG_WIDTH),
  localparam int CW = $clog2(SREG_WIDTH),
  localparam int NW = $clog2(2 * SREG_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          latch,
  input  logic          blank,
  input  logic [2:0]    din_top,
  input  logic [2:0]    din_btm,
  input  logic [3:0]    row_sel,
  output logic          w_en,
  output logic [AW-1:0] w_addr,
  output logic [11:0]   w_data_top,
  output logic [11:0]   w_data_btm,
  output logic [1:0]    plane,
  output logic          row_done,
  output logic          shift_err,
  output logic          overrun,
  output logic [15:0]   ontime,
  output logic          ontime_vld
);

  logic          sclk_q, latch_q;
  logic [NW-1:0] cnt;
  logic [CW-1:0] col;
  logic [3:0]    row_tag;
  rx_state_t     state, state_nxt;
  pixel_t        pix_top, pix_btm;

  logic sclk_rise, latch_rise, shift_en, load;
  assign sclk_rise  = sclk & ~sclk_q;
  assign latch_rise = latch & ~latch_q;
  assign shift_en   = sclk_rise & ~latch & (cnt < NW'(SREG_WIDTH));
  assign load       = latch_rise & (plane == 2'd3);

  // Edge detection, shift counting, plane sequencing and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      cnt       <= '0;
      plane     <= 2'd0;
      shift_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sclk_q  <= sclk;
      latch_q <= latch;
      if (latch_rise) begin
        shift_err <= shift_err | (cnt != NW'(SREG_WIDTH));
        cnt       <= '0;
        plane     <= plane + 2'd1;
      end else if (sclk_rise && !latch && cnt != NW'(2 * SREG_WIDTH)) begin
        cnt <= cnt + 1'b1;
      end
      if (load && state == RX_WRITE) overrun <= 1'b1;
    end
  end

  hub75_rx_half #(.SREG_WIDTH(SREG_WIDTH)) u_top (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .shift_col(cnt[CW-1:0]), .din(din_top),
    .latch_en(latch_rise), .plane(plane), .load_en(load), .rd_col(col), .rd_data(pix_top)
  );

  hub75_rx_half #(.SREG_WIDTH(SREG_WIDTH)) u_btm (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .shift_col(cnt[CW-1:0]), .din(din_btm),
    .latch_en(latch_rise), .plane(plane), .load_en(load), .rd_col(col), .rd_data(pix_btm)
  );

  // Writeout state, column counter and row tag; a new row load restarts at column 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      col     <= '0;
      row_tag <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        col     <= '0;
        row_tag <= row_sel;
      end else if (state == RX_WRITE) begin
        col <= col + 1'b1;
      end
    end
  end

  // Next state: a full row starts writeout, the last column ends it
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (load) state_nxt = RX_WRITE;
      RX_WRITE: if (!load && col == CW'(SREG_WIDTH - 1)) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  // Frame-memory write port, held at zero outside writeout
  always_comb begin
    w_en       = 1'b0;
    row_done   = 1'b0;
    w_addr     = '0;
    w_data_top = '0;
    w_data_btm = '0;
    if (state == RX_WRITE) begin
      w_en       = 1'b1;
      row_done   = (col == CW'(SREG_WIDTH - 1));
      w_addr     = AW'(row_tag) * AW'(SREG_WIDTH) + AW'(col);
      w_data_top = pix_top;
      w_data_btm = pix_btm;
    end
  end

`ifdef HUB75_RX_ONTIME_EN
  logic [15:0] on_cnt;

  // Unblanked-cycle counter, reported and cleared on every latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      on_cnt     <= '0;
      ontime     <= '0;
      ontime_vld <= 1'b0;
    end else begin
      ontime_vld <= latch_rise;
      if (latch_rise) begin
        ontime <= on_cnt;
        on_cnt <= '0;
      end else if (!blank && on_cnt != 16'hFFFF) begin
        on_cnt <= on_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign ontime       = '0;
  assign ontime_vld   = 1'b0;
`endif

endmodule
